// File: rtl/sram_port_arbiter.sv
// Arbitrates the IF and MEM pipeline stages onto one 16-bit asynchronous SRAM,
// moving each 32-bit word as two half accesses. Optional: SRAM_ARB_ROUND_ROBIN_EN.
module sram_port_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int CNT_W  = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam int WORD_W = ADDR_W - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                grant_mem_q, grant_mem_d;
  logic                op_wr_q, op_wr_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [15:0]         lo_buf_q, lo_buf_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         mem_rdata_q, mem_rdata_d;
  logic                if_ready_q, if_ready_d;
  logic                mem_ready_q, mem_ready_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [15:0]         dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                pick_mem;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // 1 = MEM was granted last, 0 = IF
  logic                last_grant_q, last_grant_d;
`endif

  // Byte-offset and out-of-range address bits do not reach the SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+1], if_addr[1:0],
                              mem_addr[31:ADDR_W+1], mem_addr[1:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_mem_d = grant_mem_q;
    op_wr_d     = op_wr_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    lo_buf_d    = lo_buf_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    pick_mem    = 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        if (mem_rd || mem_wr) begin
          pick_mem = 1'b1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
          if (if_req && last_grant_q) pick_mem = 1'b0;
`endif
        end
        if (mem_rd || mem_wr || if_req) begin
          state_d     = LO;
          cnt_d       = '0;
          grant_mem_d = pick_mem;
          op_wr_d     = pick_mem && mem_wr;
          word_d      = pick_mem ? mem_addr[ADDR_W:2] : if_addr[ADDR_W:2];
          wdata_d     = mem_wdata;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
          last_grant_d = pick_mem;
`endif
        end
      end
      LO: begin
        if (cnt_q == CNT_LAST) begin
          if (!op_wr_q) lo_buf_d = sram_dq_in;
          state_d = HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HI: begin
        if (cnt_q == CNT_LAST) begin
          // Upper half is taken straight from the pad so the word lands with ready.
          if (!op_wr_q) begin
            if (grant_mem_q) mem_rdata_d = {sram_dq_in, lo_buf_q};
            else             if_rdata_d  = {sram_dq_in, lo_buf_q};
          end
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    if_ready_d  = (state_d == DONE) && !grant_mem_d;
    mem_ready_d = (state_d == DONE) &&  grant_mem_d;
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    dq_oe_d     = 1'b0;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    if ((state_d == LO) || (state_d == HI)) begin
      ce_n_d      = 1'b0;
      sram_addr_d = {word_d, (state_d == HI)};
      if (op_wr_d) begin
        dq_oe_d  = 1'b1;
        dq_out_d = (state_d == HI) ? wdata_d[31:16] : wdata_d[15:0];
        // First cycle of each phase is address setup with we_n still high.
        we_n_d   = (cnt_d == '0);
      end else begin
        oe_n_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      grant_mem_q <= 1'b0;
      op_wr_q     <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      lo_buf_q    <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_mem_q <= grant_mem_d;
      op_wr_q     <= op_wr_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      lo_buf_q    <= lo_buf_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign if_rdata    = if_rdata_q;
  assign if_ready    = if_ready_q;
  assign mem_rdata   = mem_rdata_q;
  assign mem_ready   = mem_ready_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the board's single 16-bit asynchronous SRAM between two requesters of the 5-stage MIPS pipeline: the IF stage (instruction read) and the MEM stage (data read/write).
- Every 32-bit word moves as two 16-bit half accesses, low half first.
- Per-requester ready pulses tell the pipeline when to advance. The pipeline's existing stall/freeze logic holds a stage while its ready is low.

Parameters:
- ADDR_W, 18, SRAM address width in 16-bit half-words.
- WAIT_CYCLES, 2, cycles per half access. Legal range ≥2.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  IF read request (level, held until if_ready)
- if_addr  in  32  IF byte address
- if_rdata  out  32  instruction word
- if_ready  out  1  one-cycle pulse: IF transfer complete
- mem_rd  in  1  MEM read request (level)
- mem_wr  in  1  MEM write request (level)
- mem_addr  in  32  MEM byte address
- mem_wdata  in  32  store data
- mem_rdata  out  32  load data
- mem_ready  out  1  one-cycle pulse: MEM transfer complete
- sram_addr  out  ADDR_W  half-word address
- sram_dq_out  out  16  write data to pad
- sram_dq_oe  out  1  pad output enable
- sram_dq_in  in  16  read data from pad
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low

Behaviour:
- All outputs are registered.
- Reset (async, any state) forces:
  - state IDLE, counter 0;
  - if_ready=0, mem_ready=0, if_rdata=0, mem_rdata=0;
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
- FSM states: IDLE, LO, HI, DONE.
- IDLE, grant selection:
  - mem_rd|mem_wr → grant MEM; else if_req → grant IF; else stay in IDLE.
  - MEM wins ties with IF; the older instruction goes first.
  - Latch the grant, the op (write if mem_wr, else read; mem_rd&mem_wr together is treated as a write), the word address and the write data.
  - Go to LO with counter=0.
- Address mapping:
  - word = addr[ADDR_W:2]; addr[1:0] and all bits above ADDR_W are ignored.
  - LO drives sram_addr={word,1'b0}; HI drives {word,1'b1}.
- LO and HI each last exactly WAIT_CYCLES cycles. The counter runs 0..WAIT_CYCLES-1, then advances LO→HI or HI→DONE.
- Read phase:
  - ce_n=0, oe_n=0, we_n=1, dq_oe=0.
  - sram_dq_in is captured on the last phase cycle: LO → bits[15:0], HI → bits[31:16].
- Write phase:
  - ce_n=0, oe_n=1, dq_oe=1; sram_dq_out = wdata[15:0] in LO, wdata[31:16] in HI.
  - we_n=1 on the first phase cycle (address setup), 0 for the remaining cycles.
- DONE:
  - Pulse the granted ready for one cycle.
  - Load the assembled word into if_rdata or mem_rdata (write: mem_rdata unchanged).
  - Release ce_n/oe_n/we_n/dq_oe to idle values. Next state IDLE.
- Latency: request visible in IDLE at cycle 0 → ready high at cycle 2*WAIT_CYCLES+1 (5 with the default).
- Back-to-back: one IDLE bubble between transfers. A request still held in IDLE after its ready pulse is treated as a new request, so requesters must drop or advance their request on ready.
- Request dropped mid-transfer: the transfer still completes and ready still pulses.
- Rdata registers hold their value until the next completion for that requester.
- Non-granted ready stays 0.

Optional Feature:
- Macro SRAM_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last_grant register (reset = IF). On a tie in IDLE, grant the requester not granted last, so IF cannot starve under continuous MEM traffic.
- Undefined: fixed MEM-over-IF priority as above.

Test Plan:
- IF read alone: preload SRAM half 0x00010=0x5678, 0x00011=0x1234; if_req=1, if_addr=0x20 → if_ready pulses at cycle 5, if_rdata=0x12345678; sram_addr sequence 0x10,0x10,0x11,0x11.
- MEM write then read: mem_wr, addr 0x40, wdata 0xDEADBEEF → we_n pattern 1,0 per phase; halves 0x20=0xBEEF, 0x21=0xDEAD; then mem_rd 0x40 → mem_rdata=0xDEADBEEF.
- Simultaneous if_req and mem_rd in the same cycle → MEM served first (mem_ready at cycle 5), IF second (if_ready at cycle 11); if_ready=0 during the MEM transfer.
- Reset asserted in HI of a write → outputs return to reset values immediately, no further we_n low, FSM in IDLE after release.
- Address wrap: if_addr=0x0010_0020 reads the same word as 0x20 with ADDR_W=18.
- With SRAM_ARB_ROUND_ROBIN_EN defined: mem_rd and if_req both held continuously → grants alternate MEM, IF, MEM, IF. Without the macro → MEM every grant, IF never.
